rf_wb_scheduler: RTL and testbench

Write-back scheduler for the 32×32 register file. It shares the file's single write port (WE3/A3/WD3) between two write-back requesters: the single-cycle ALU path and the multi-cycle load/store unit (LSU). Arbitration is round-robin, and the granted write is registered onto the port. A 32-bit pending-destination scoreboard lets the issue stage stall on RAW/WAW hazards until the write has landed in the file.

---
 rtl/rf_wb_if.sv | 48 ++++
 rtl/rf_wb_scheduler.sv | 110 +++++++++++
 tb/tb_rf_wb_scheduler.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_if.sv
// Write-back request, register-file port and hazard-check signals shared
// between the issue/execute side and rf_wb_scheduler.
interface rf_wb_if;
    logic        alu_valid_i;
    logic [4:0]  alu_addr_i;
    logic [31:0] alu_data_i;
    logic        alu_ready_o;

    logic        lsu_valid_i;
    logic [4:0]  lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic        lsu_ready_o;

    logic        rf_we_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_wdata_o;

    logic        iss_valid_i;
    logic [4:0]  iss_addr_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic        rs1_busy_o;
    logic        rs2_busy_o;
    logic        rd_busy_o;
    logic        err_o;

    // Scheduler side
    modport slave (
        input  alu_valid_i, alu_addr_i, alu_data_i,
        output alu_ready_o,
        input  lsu_valid_i, lsu_addr_i, lsu_data_i,
        output lsu_ready_o,
        output rf_we_o, rf_addr_o, rf_wdata_o,
        input  iss_valid_i, iss_addr_i, rs1_addr_i, rs2_addr_i,
        output rs1_busy_o, rs2_busy_o, rd_busy_o, err_o
    );

    // Requester / issue-stage side
    modport master (
        output alu_valid_i, alu_addr_i, alu_data_i,
        input  alu_ready_o,
        output lsu_valid_i, lsu_addr_i, lsu_data_i,
        input  lsu_ready_o,
        input  rf_we_o, rf_addr_o, rf_wdata_o,
        output iss_valid_i, iss_addr_i, rs1_addr_i, rs2_addr_i,
        input  rs1_busy_o, rs2_busy_o, rd_busy_o, err_o
    );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Round-robin arbiter sharing the register file write port between the ALU and
// LSU write-back paths, with a pending-destination scoreboard for hazard stalls.
module rf_wb_scheduler (
    input  logic    clk,
    input  logic    rst,
    rf_wb_if.slave  wb
);
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_LSU = 1'b1
    } prio_t;

    prio_t prio_q, prio_d;

    logic              alu_rdy, lsu_rdy;
    logic              alu_go, lsu_go;
    logic              vld_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;

    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] wdata_p1;

    logic [NREG-1:0]   pending_q, pending_d;
    logic [NREG-1:0]   set_mask, clr_mask;
    logic              err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) prio_q <= PRIO_ALU;
        else     prio_q <= prio_d;
    end

    // Stage p0: arbitration and grant mux
    always_comb begin
        alu_rdy  = 1'b0;
        lsu_rdy  = 1'b0;
        alu_go   = 1'b0;
        lsu_go   = 1'b0;
        prio_d   = prio_q;
        vld_p0   = 1'b0;
        addr_p0  = '0;
        wdata_p0 = '0;

        alu_rdy = !rst && (!wb.lsu_valid_i || prio_q == PRIO_ALU);
        lsu_rdy = !rst && (!wb.alu_valid_i || prio_q == PRIO_LSU);
        alu_go  = wb.alu_valid_i && alu_rdy;
        lsu_go  = wb.lsu_valid_i && lsu_rdy;

        // Only a conflict moves priority, and it moves to whoever lost.
        if (wb.alu_valid_i && wb.lsu_valid_i)
            prio_d = alu_go ? PRIO_LSU : PRIO_ALU;

        vld_p0   = alu_go || lsu_go;
        addr_p0  = lsu_go ? wb.lsu_addr_i : wb.alu_addr_i;
        wdata_p0 = lsu_go ? wb.lsu_data_i : wb.alu_data_i;
    end

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (wb.iss_valid_i && wb.iss_addr_i != '0)
            set_mask = NREG'(1) << wb.iss_addr_i;
        if (vld_p1)
            clr_mask = NREG'(1) << addr_p1;
        // A new allocation behind a completing write must survive, so set wins.
        pending_d    = (pending_q & ~clr_mask) | set_mask;
        pending_d[0] = 1'b0;
        err_d = err_q || (vld_p0 && addr_p0 != '0 && !pending_q[addr_p0]);
    end

    // Stage p1: registered write port and scoreboard
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            addr_p1   <= '0;
            wdata_p1  <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            vld_p1 <= vld_p0 && addr_p0 != '0;
            if (vld_p0) begin
                addr_p1  <= addr_p0;
                wdata_p1 <= wdata_p0;
            end
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign wb.alu_ready_o = alu_rdy;
    assign wb.lsu_ready_o = lsu_rdy;
    assign wb.rf_we_o     = vld_p1;
    assign wb.rf_addr_o   = addr_p1;
    assign wb.rf_wdata_o  = wdata_p1;
    assign wb.err_o       = err_q;

    // pending_q[0] is never set, so x0 reads as not busy.
    assign wb.rs1_busy_o = pending_q[wb.rs1_addr_i];
    assign wb.rs2_busy_o = pending_q[wb.rs2_addr_i];
    assign wb.rd_busy_o  = pending_q[wb.iss_addr_i];

    a_single_grant: assert property (@(posedge clk) !(alu_go && lsu_go));
    a_x0_never_pending: assert property (@(posedge clk) disable iff (rst) !pending_q[0]);
    a_no_we_to_x0: assert property (@(posedge clk) disable iff (rst) !(vld_p1 && addr_p1 == '0));
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Randomized and directed bench for rf_wb_scheduler against a register-level
// behavioural model of the write-back rules.
module tb_rf_wb_scheduler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_wb_if wb();

    rf_wb_scheduler dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    int total = 0;
    int bad   = 0;

    // Model state: who wins the next conflict, set of pending registers,
    // last write presented to the file, sticky error.
    bit        m_turn_lsu;
    bit        m_pend [32];
    bit        m_we;
    bit [4:0]  m_addr;
    bit [31:0] m_data;
    bit        m_err;
    bit        a_go, l_go;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_turn_lsu = 1'b0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_err  = 1'b0;
    endtask

    // Inputs are set by the caller just after a falling edge; step checks every
    // output against the model, advances the model and moves to the next falling edge.
    task automatic step();
        bit        a_rdy, l_rdy, go;
        bit [4:0]  ga;
        bit [31:0] gd;
        #1;
        a_rdy = !rst && (!wb.lsu_valid_i || !m_turn_lsu);
        l_rdy = !rst && (!wb.alu_valid_i ||  m_turn_lsu);
        chk("alu_ready", wb.alu_ready_o, a_rdy);
        chk("lsu_ready", wb.lsu_ready_o, l_rdy);
        chk("rf_we",     wb.rf_we_o,     m_we);
        chk("rf_addr",   wb.rf_addr_o,   m_addr);
        chk("rf_wdata",  wb.rf_wdata_o,  m_data);
        chk("err",       wb.err_o,       m_err);
        chk("rs1_busy",  wb.rs1_busy_o,  m_pend[wb.rs1_addr_i]);
        chk("rs2_busy",  wb.rs2_busy_o,  m_pend[wb.rs2_addr_i]);
        chk("rd_busy",   wb.rd_busy_o,   m_pend[wb.iss_addr_i]);

        a_go = wb.alu_valid_i && a_rdy;
        l_go = wb.lsu_valid_i && l_rdy;
        if (rst) begin
            model_reset();
        end else begin
            go = a_go || l_go;
            ga = l_go ? wb.lsu_addr_i : wb.alu_addr_i;
            gd = l_go ? wb.lsu_data_i : wb.alu_data_i;
            if (go && ga != 0 && !m_pend[ga]) m_err = 1'b1;
            if (m_we) m_pend[m_addr] = 1'b0;
            if (wb.iss_valid_i && wb.iss_addr_i != 0) m_pend[wb.iss_addr_i] = 1'b1;
            if (wb.alu_valid_i && wb.lsu_valid_i) m_turn_lsu = a_go;
            if (go) begin
                m_we   = (ga != 0);
                m_addr = ga;
                m_data = gd;
            end else begin
                m_we = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_alu(input bit v, input bit [4:0] a, input bit [31:0] d);
        wb.alu_valid_i = v; wb.alu_addr_i = a; wb.alu_data_i = d;
    endtask

    task automatic set_lsu(input bit v, input bit [4:0] a, input bit [31:0] d);
        wb.lsu_valid_i = v; wb.lsu_addr_i = a; wb.lsu_data_i = d;
    endtask

    task automatic set_iss(input bit v, input bit [4:0] a);
        wb.iss_valid_i = v; wb.iss_addr_i = a;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_alu(0, 0, 0);
        set_lsu(0, 0, 0);
        set_iss(0, 0);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_alu(0, 0, 0);
        set_lsu(0, 0, 0);
        set_iss(0, 0);
        wb.rs1_addr_i = 0;
        wb.rs2_addr_i = 0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        chk("reset rf_we", wb.rf_we_o, 0);
        chk("reset rf_addr", wb.rf_addr_o, 0);
        chk("reset rf_wdata", wb.rf_wdata_o, 0);
        chk("reset err", wb.err_o, 0);
        chk("reset alu_ready", wb.alu_ready_o, 0);
        chk("reset lsu_ready", wb.lsu_ready_o, 0);
        do_reset();

        // Single ALU write to a non-pending register
        set_alu(1, 5, 32'hDEADBEEF);
        step();
        chk("t1 rf_we", wb.rf_we_o, 1);
        chk("t1 rf_addr", wb.rf_addr_o, 5);
        chk("t1 rf_wdata", wb.rf_wdata_o, 32'hDEADBEEF);
        chk("t1 err", wb.err_o, 1);
        set_alu(0, 0, 0);
        step();
        chk("t1 rf_we off", wb.rf_we_o, 0);

        // Both requesters valid out of reset: ALU, then LSU, priority back to ALU
        rst = 1'b1;
        set_alu(1, 3, 32'h1);
        set_lsu(1, 4, 32'h2);
        step();
        rst = 1'b0;
        step();
        chk("t2 first addr", wb.rf_addr_o, 3);
        chk("t2 first we", wb.rf_we_o, 1);
        step();
        chk("t2 second addr", wb.rf_addr_o, 4);
        chk("t2 second data", wb.rf_wdata_o, 32'h2);
        chk("t2 second we", wb.rf_we_o, 1);
        set_alu(1, 10, 32'hA);
        set_lsu(1, 11, 32'hB);
        #1;
        chk("t2 prio alu_ready", wb.alu_ready_o, 1);
        chk("t2 prio lsu_ready", wb.lsu_ready_o, 0);
        step();
        set_alu(0, 0, 0);
        set_lsu(0, 0, 0);
        step();

        // Issue x7, write it three cycles later
        do_reset();
        wb.rs1_addr_i = 7;
        set_iss(1, 7);
        step();
        set_iss(0, 0);
        chk("t3 busy after issue", wb.rs1_busy_o, 1);
        step();
        step();
        set_lsu(1, 7, 32'h55);
        step();
        set_lsu(0, 0, 0);
        chk("t3 busy on we cycle", wb.rs1_busy_o, 1);
        chk("t3 we", wb.rf_we_o, 1);
        step();
        chk("t3 busy cleared", wb.rs1_busy_o, 0);
        chk("t3 err", wb.err_o, 0);

        // Reallocation on the completing-write edge keeps the bit set
        do_reset();
        wb.rs1_addr_i = 9;
        set_iss(1, 9);
        step();
        set_iss(0, 0);
        set_alu(1, 9, 32'h99);
        step();
        set_alu(0, 0, 0);
        chk("t4 we x9", wb.rf_we_o, 1);
        set_iss(1, 9);
        step();
        set_iss(0, 0);
        chk("t4 set wins", wb.rs1_busy_o, 1);
        step();
        chk("t4 still busy", wb.rs1_busy_o, 1);

        // Write to x0 is accepted and dropped
        do_reset();
        wb.rs1_addr_i = 0;
        set_alu(1, 0, 32'hFFFFFFFF);
        #1;
        chk("t5 alu_ready", wb.alu_ready_o, 1);
        step();
        set_alu(0, 0, 0);
        chk("t5 we x0", wb.rf_we_o, 0);
        chk("t5 err", wb.err_o, 0);
        set_iss(1, 0);
        step();
        set_iss(0, 0);
        chk("t5 x0 busy", wb.rs1_busy_o, 0);

        // Reset while an LSU write is in flight
        do_reset();
        wb.rs1_addr_i = 2;
        wb.rs2_addr_i = 8;
        set_iss(1, 2);
        step();
        set_iss(1, 8);
        step();
        set_iss(0, 0);
        set_alu(1, 3, 32'h3);
        set_lsu(1, 8, 32'h88);
        step();
        set_alu(0, 0, 0);
        step();
        chk("t6 lsu we", wb.rf_we_o, 1);
        chk("t6 x2 busy", wb.rs1_busy_o, 1);
        rst = 1'b1;
        set_lsu(1, 2, 32'h22);
        #1;
        chk("t6 rst alu_ready", wb.alu_ready_o, 0);
        chk("t6 rst lsu_ready", wb.lsu_ready_o, 0);
        step();
        chk("t6 we dropped", wb.rf_we_o, 0);
        chk("t6 rs1 cleared", wb.rs1_busy_o, 0);
        chk("t6 rs2 cleared", wb.rs2_busy_o, 0);
        step();
        rst = 1'b0;
        set_alu(1, 12, 32'hC);
        set_lsu(1, 13, 32'hD);
        #1;
        chk("t6 prio alu_ready", wb.alu_ready_o, 1);
        chk("t6 prio lsu_ready", wb.lsu_ready_o, 0);
        step();
        set_alu(0, 0, 0);
        set_lsu(0, 0, 0);
        step();

        // Random traffic; a requester only changes its request once granted or idle
        do_reset();
        a_go = 1'b0;
        l_go = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (a_go || !wb.alu_valid_i)
                set_alu(bit'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom);
            if (l_go || !wb.lsu_valid_i)
                set_lsu(bit'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom);
            set_iss(bit'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
            wb.rs1_addr_i = 5'($urandom_range(0, 7));
            wb.rs2_addr_i = 5'($urandom_range(0, 31));
            rst = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
